hazard_scoreboard: RTL and testbench

Parametrised hazard/forwarding unit for the pipelined RISC-V core, placed between the ID and EX stages. It keeps a per-register countdown scoreboard for multi-cycle results (loads, multiply, divide) and holds ID with a stall while any source or destination register is still pending. For operands that are ready, it produces EX-stage operand forward selects with the MEM stage taking priority over WB.

---
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard scoreboard plus EX operand forwarding.
// Each register has a countdown of cycles until its multi-cycle result is
// forwardable. ID stalls while any source or the destination is pending.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall_cnt/fwd_cnt.

// One countdown cell per architectural register.
module hazard_sb_cell #(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LAT_W-1:0] lat,
   output logic [LAT_W-1:0] rem
);
   logic [LAT_W-1:0] rem_q, rem_d;

   // Reload on issue, otherwise count down and hold at zero.
   always_comb begin
      rem_d = rem_q;
      if (load)
         rem_d = lat;
      else if (rem_q != '0)
         rem_d = rem_q - 1'b1;
   end

   // Counter state.
   always_ff @(posedge clk) begin
      if (rst) rem_q <= '0;
      else     rem_q <= rem_d;
   end

   assign rem = rem_q;
endmodule

module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int LAT_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [ADDR_W-1:0]   id_rs1,
   input  logic [ADDR_W-1:0]   id_rs2,
   input  logic                id_rs1_used,
   input  logic                id_rs2_used,
   input  logic [ADDR_W-1:0]   id_rd,
   input  logic                id_rd_we,
   input  logic [LAT_W-1:0]    id_lat,
   input  logic                flush,
   output logic                id_ready,
   input  logic [ADDR_W-1:0]   ex_rs1,
   input  logic [ADDR_W-1:0]   ex_rs2,
   input  logic [ADDR_W-1:0]   mem_rd,
   input  logic [ADDR_W-1:0]   wb_rd,
   input  logic                mem_RegWEn,
   input  logic                wb_RegWEn,
   input  logic                mem_is_load,
   output logic [1:0]          ForwardASel,
   output logic [1:0]          ForwardBSel,
   output logic [NUM_REGS-1:0] sb_busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]         stall_cnt,
   output logic [31:0]         fwd_cnt
`endif
);
   localparam int IDX_N = 1 << ADDR_W;

   logic [NUM_REGS-1:0][LAT_W-1:0] rem;
   logic [IDX_N-1:0]               busy_ext;
   logic                           issue_we;

   // x0 never has a pending result.
   assign rem[0] = '0;

   // Only a real issue (not stalled, not flushed) arms a counter.
   assign issue_we = id_valid & id_ready & ~flush & id_rd_we;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cell
      hazard_sb_cell #(.LAT_W(LAT_W)) u_cell (
         .clk  (clk),
         .rst  (rst),
         .load (issue_we && (id_rd == ADDR_W'(r))),
         .lat  (id_lat),
         .rem  (rem[r])
      );
   end

   // Busy vector, zero-extended so any index decodes safely.
   always_comb begin
      sb_busy  = '0;
      for (int r = 0; r < NUM_REGS; r++)
         sb_busy[r] = |rem[r];
      busy_ext = '0;
      busy_ext[NUM_REGS-1:0] = sb_busy;
   end

   // Stall on pending sources (RAW) and pending destination (WAW).
   always_comb begin
      id_ready = ~(id_rs1_used & busy_ext[id_rs1])
               & ~(id_rs2_used & busy_ext[id_rs2])
               & ~(id_rd_we    & busy_ext[id_rd]);
   end

   // Forward selects: MEM beats WB; a load in MEM is never a forward source.
   always_comb begin
      ForwardASel = 2'b00;
      ForwardBSel = 2'b00;
      if (mem_RegWEn && !mem_is_load && mem_rd != '0 && mem_rd == ex_rs1)
         ForwardASel = 2'b10;
      else if (wb_RegWEn && wb_rd != '0 && wb_rd == ex_rs1)
         ForwardASel = 2'b01;
      if (mem_RegWEn && !mem_is_load && mem_rd != '0 && mem_rd == ex_rs2)
         ForwardBSel = 2'b10;
      else if (wb_RegWEn && wb_rd != '0 && wb_rd == ex_rs2)
         ForwardBSel = 2'b01;
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;
   logic [32:0] fwd_sum;
   logic [1:0]  fwd_inc;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (id_valid && !id_ready && !flush && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 32'd1;
      fwd_inc   = {1'b0, |ForwardASel} + {1'b0, |ForwardBSel};
      fwd_sum   = {1'b0, fwd_cnt_q} + {31'd0, fwd_inc};
      fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
   end

   // Counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_rd_we = 0, flush = 0;
   logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
   logic [2:0]  id_lat = 0;
   logic        id_ready;
   logic [4:0]  ex_rs1 = 0, ex_rs2 = 0, mem_rd = 0, wb_rd = 0;
   logic        mem_RegWEn = 0, wb_RegWEn = 0, mem_is_load = 0;
   logic [1:0]  ForwardASel, ForwardBSel;
   logic [31:0] sb_busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, fwd_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int n;

   hazard_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LAT_W(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_rd_we(id_rd_we), .id_lat(id_lat), .flush(flush), .id_ready(id_ready),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .mem_RegWEn(mem_RegWEn), .wb_RegWEn(wb_RegWEn), .mem_is_load(mem_is_load),
      .ForwardASel(ForwardASel), .ForwardBSel(ForwardBSel), .sb_busy(sb_busy)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and settle 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick(); tick();
      rst = 0;
      tick();
      chk("rst_ready", 32'(id_ready), 32'd1);
      chk("rst_busy",  sb_busy, 32'd0);
      chk("rst_fa",    32'(ForwardASel), 32'd0);
      chk("rst_fb",    32'(ForwardBSel), 32'd0);

      // Load-use: load x5 (lat 1), then consumer of x5.
      id_valid = 1; id_rd = 5; id_rd_we = 1; id_lat = 1;
      #1 chk("ld_issue_ready", 32'(id_ready), 32'd1);
      tick();
      id_rd = 6; id_lat = 0; id_rs1 = 5; id_rs1_used = 1;
      #1 chk("ld_use_stall", 32'(id_ready), 32'd0);
      chk("ld_busy5", sb_busy, 32'h20);
      tick();
      chk("ld_use_go", 32'(id_ready), 32'd1);
      chk("ld_busy_clr", sb_busy, 32'd0);
      tick();
      id_valid = 0; id_rs1_used = 0; id_rd_we = 0;
      ex_rs1 = 5; wb_rd = 5; wb_RegWEn = 1;
      #1 chk("ld_fwd_wb", 32'(ForwardASel), 32'd1);
      chk("alu_no_busy", sb_busy, 32'd0);

      // MEM vs WB priority, and load in MEM.
      mem_rd = 7; wb_rd = 7; mem_RegWEn = 1; wb_RegWEn = 1; ex_rs2 = 7; ex_rs1 = 7;
      #1 chk("prio_fb_mem", 32'(ForwardBSel), 32'd2);
      chk("prio_fa_mem", 32'(ForwardASel), 32'd2);
      mem_is_load = 1;
      #1 chk("ldmem_fb_wb", 32'(ForwardBSel), 32'd1);
      mem_is_load = 0; mem_rd = 8;
      #1 chk("wb_only_fb", 32'(ForwardBSel), 32'd1);

      // x0 is never forwarded nor tracked.
      mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
      #1 chk("x0_fa", 32'(ForwardASel), 32'd0);
      mem_RegWEn = 0; wb_RegWEn = 0; ex_rs2 = 0;
      id_valid = 1; id_rd = 0; id_rd_we = 1; id_lat = 5;
      tick();
      chk("x0_busy", sb_busy, 32'd0);
      chk("x0_ready", 32'(id_ready), 32'd1);

      // WAW on a divide to x9 (lat 4): exactly 4 stall cycles.
      id_rd = 9; id_lat = 4;
      tick();
      id_lat = 0;
      #1 chk("div_busy9", sb_busy, 32'h200);
      n = 0;
      while (!id_ready && n < 10) begin
         n++;
         tick();
      end
      chk("waw_stall_cycles", 32'(n), 32'd4);
      tick();
      chk("waw_alu_busy", sb_busy, 32'd0);

      // Reset on the second stall cycle releases ID immediately.
      id_lat = 4;
      tick();
      chk("rst_stall1", 32'(id_ready), 32'd0);
      tick();
      chk("rst_stall2", 32'(id_ready), 32'd0);
      rst = 1;
      tick();
      rst = 0; id_valid = 0;
      chk("rst_mid_ready", 32'(id_ready), 32'd1);
      chk("rst_mid_busy", sb_busy, 32'd0);

      // Flushed issue never arms a counter.
      id_valid = 1; flush = 1; id_rd = 3; id_rd_we = 1; id_lat = 2;
      tick();
      flush = 0; id_valid = 0;
      chk("flush_busy", sb_busy, 32'd0);

      // Lat 3 producer gives a 3-cycle RAW stall from a clean reset.
      rst = 1;
      tick();
      rst = 0;
      id_valid = 1; id_rd = 3; id_rd_we = 1; id_lat = 3;
      tick();
      id_rd_we = 0; id_rs2 = 3; id_rs2_used = 1;
      n = 0;
      #1;
      while (!id_ready && n < 10) begin
         n++;
         tick();
      end
      chk("raw3_stall_cycles", 32'(n), 32'd3);
`ifdef HAZARD_STATS_EN
      chk("stall_cnt3", stall_cnt, 32'd3);
      chk("fwd_cnt0", fwd_cnt, 32'd0);
`endif
      id_valid = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
